// File: rtl/matrix_dim_scanner.sv
// matrix_dim_scanner: walks the metadata store and reports slots holding valid matrices of the requested dimensions
module matrix_dim_scanner #(
    parameter int NUM_SLOTS = 8,
    parameter int ID_WIDTH  = 3,
    parameter int DIM_WIDTH = 3,
    parameter int MAX_DIM   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 scan_start,
    input  logic [DIM_WIDTH-1:0] target_m,
    input  logic [DIM_WIDTH-1:0] target_n,
    output logic                 scan_busy,
    output logic                 scan_done,
    output logic                 scan_err,
    output logic [NUM_SLOTS-1:0] match_mask,
    output logic [ID_WIDTH:0]    match_count,
    output logic [ID_WIDTH-1:0]  first_id,
    output logic                 found,
    output logic                 meta_rd_en,
    output logic [ID_WIDTH-1:0]  meta_rd_addr,
    input  logic                 meta_valid,
    input  logic [DIM_WIDTH-1:0] meta_rows,
    input  logic [DIM_WIDTH-1:0] meta_cols
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    localparam logic [ID_WIDTH-1:0]  LAST = ID_WIDTH'(NUM_SLOTS - 1);
    localparam logic [DIM_WIDTH-1:0] MAXD = DIM_WIDTH'(MAX_DIM);
    state_t state, state_nxt;
    logic [DIM_WIDTH-1:0] tm, tn;
    logic wild, rd_q, legal, accept, hit;
    logic [ID_WIDTH-1:0] addr_q;
    assign accept = state == IDLE && scan_start;
    assign legal = (target_m == '0 && target_n == '0) ||
                   (target_m != '0 && target_n != '0 && target_m <= MAXD && target_n <= MAXD);
    // compare stage sees RAM data one cycle after the read strobe
    assign hit = rd_q && meta_valid && (wild || (meta_rows == tm && meta_cols == tn));
    assign meta_rd_en = state == ISSUE;
    assign scan_busy = state != IDLE;
    assign scan_done = state == DONE;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE  ? (scan_start ? (legal ? ISSUE : DONE) : IDLE) :
                    state == ISSUE ? (meta_rd_addr == LAST ? DRAIN : ISSUE) :
                    state == DRAIN ? DONE : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tm <= '0;
            tn <= '0;
            wild <= 1'b0;
            rd_q <= 1'b0;
            addr_q <= '0;
            scan_err <= 1'b0;
            match_mask <= '0;
            match_count <= '0;
            first_id <= '0;
            found <= 1'b0;
            meta_rd_addr <= '0;
        end else if (accept) begin
            tm <= target_m;
            tn <= target_n;
            wild <= target_m == '0 && target_n == '0;
            rd_q <= 1'b0;
            scan_err <= !legal;
            match_mask <= '0;
            match_count <= '0;
            first_id <= '0;
            found <= 1'b0;
            meta_rd_addr <= '0;
        end else begin
            rd_q <= meta_rd_en;
            addr_q <= meta_rd_addr;
            if (meta_rd_en) meta_rd_addr <= meta_rd_addr == LAST ? '0 : meta_rd_addr + 1'b1;
            if (hit) begin
                match_mask[addr_q] <= 1'b1;
                match_count <= match_count + 1'b1;
                if (match_count == '0) first_id <= addr_q;
            end
            if (state == DRAIN) found <= hit || match_count != '0;
        end
    end
endmodule
